// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge core: two line buffers, 3x3 window, two-stage pipeline.
// Optional frame counter output enabled by defining SOBEL_STREAM_STATS_EN.
module sobel_stream #(
  parameter int WIDTH_P  = 8,
  parameter int LINE_W_P = 640,
  parameter int LINES_P  = 480
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic [1:0]         mode_i,
  input  logic [WIDTH_P-1:0] thresh_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH_P-1:0] data_o,
  output logic               eol_o,
  output logic               eof_o
`ifdef SOBEL_STREAM_STATS_EN
  ,
  output logic [15:0]        frame_cnt_o
`endif
);

  localparam int COL_W = $clog2(LINE_W_P);
  localparam int ROW_W = $clog2(LINES_P);
  localparam int AW    = WIDTH_P + 4;
  localparam int MW    = WIDTH_P + 3;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W_P - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LINES_P - 1);

  typedef enum logic [1:0] {MODE_MAG, MODE_BIN, MODE_GX, MODE_GY} mode_e;

  logic               en, accept, first_px, last_col, last_row;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [WIDTH_P-1:0] lb1 [LINE_W_P];
  logic [WIDTH_P-1:0] lb2 [LINE_W_P];
  logic [WIDTH_P-1:0] win [3][3];
  mode_e              mode_q, s1_mode;
  logic [WIDTH_P-1:0] thresh_q, s1_thresh;
  logic               s1_valid, s1_eol, s1_eof;

  assign en       = ~valid_o | ready_i;
  assign ready_o  = en;
  assign accept   = valid_i & en;
  assign first_px = (col == '0) && (row == '0);
  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);

  // lb1 holds row-1, lb2 holds row-2; read-before-write gives the old column
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1[col] <= data_i;
      lb2[col] <= lb1[col];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col       <= '0;
      row       <= '0;
      mode_q    <= MODE_MAG;
      thresh_q  <= '0;
      s1_valid  <= 1'b0;
      s1_eol    <= 1'b0;
      s1_eof    <= 1'b0;
      s1_mode   <= MODE_MAG;
      s1_thresh <= '0;
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      col <= last_col ? '0 : col + 1'b1;
      if (last_col) row <= last_row ? '0 : row + 1'b1;
      if (first_px) begin
        mode_q   <= mode_e'(mode_i);
        thresh_q <= thresh_i;
      end
      // mode travels with the pixel so a new frame's latch cannot alter the previous frame's tail
      s1_mode   <= first_px ? mode_e'(mode_i) : mode_q;
      s1_thresh <= first_px ? thresh_i : thresh_q;
      s1_valid  <= (row >= ROW_W'(2)) && (col >= COL_W'(2));
      s1_eol    <= last_col;
      s1_eof    <= last_col && last_row;
      for (int unsigned r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb2[col];
      win[1][2] <= lb1[col];
      win[2][2] <= data_i;
    end else if (en) begin
      s1_valid <= 1'b0;
    end
  end

  function automatic logic [AW-1:0] ext(input logic [WIDTH_P-1:0] v);
    return AW'(v);
  endfunction

  function automatic logic [WIDTH_P-1:0] sat(input logic [MW-1:0] v);
    return (|v[MW-1:WIDTH_P]) ? '1 : v[WIDTH_P-1:0];
  endfunction

  logic [AW-1:0]      gx, gy;
  logic [MW-1:0]      ax, ay, mag;
  logic [WIDTH_P-1:0] result;

  always_comb begin
    gx = (ext(win[0][2]) + (ext(win[1][2]) << 1) + ext(win[2][2]))
       - (ext(win[0][0]) + (ext(win[1][0]) << 1) + ext(win[2][0]));
    gy = (ext(win[2][0]) + (ext(win[2][1]) << 1) + ext(win[2][2]))
       - (ext(win[0][0]) + (ext(win[0][1]) << 1) + ext(win[0][2]));
    ax  = gx[AW-1] ? MW'(-gx) : MW'(gx);
    ay  = gy[AW-1] ? MW'(-gy) : MW'(gy);
    mag = ax + ay;
    result = '0;
    case (s1_mode)
      MODE_MAG: result = sat(mag);
      MODE_BIN: result = (sat(mag) >= s1_thresh) ? '1 : '0;
      MODE_GX:  result = sat(ax);
      MODE_GY:  result = sat(ay);
      default:  result = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      eol_o   <= 1'b0;
      eof_o   <= 1'b0;
    end else if (en) begin
      valid_o <= s1_valid;
      eol_o   <= s1_valid && s1_eol;
      eof_o   <= s1_valid && s1_eof;
      if (s1_valid) data_o <= result;
    end
  end

`ifdef SOBEL_STREAM_STATS_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) frame_cnt_o <= '0;
    else if (valid_o && ready_i && eof_o) frame_cnt_o <= frame_cnt_o + 1'b1;
  end
`endif

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream (8x6 frames) against a frame-level Sobel model.
module tb_sobel_stream;
  localparam int LW = 8;
  localparam int LN = 6;

  logic       clk = 1'b0;
  logic       rstn_i = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
  logic       ready_o, valid_o, eol_o, eof_o;
  logic [7:0] data_i = '0, thresh_i = '0, data_o;
  logic [1:0] mode_i = '0;
`ifdef SOBEL_STREAM_STATS_EN
  logic [15:0] frame_cnt_o;
`endif

  sobel_stream #(.WIDTH_P(8), .LINE_W_P(LW), .LINES_P(LN)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .mode_i(mode_i), .thresh_i(thresh_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .eol_o(eol_o), .eof_o(eof_o)
`ifdef SOBEL_STREAM_STATS_EN
    , .frame_cnt_o(frame_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic eol; logic eof; } out_t;

  int   checks = 0, failures = 0, cyc = 0, acc_cyc = 0, first_valid_cyc = -1;
  bit   bp_en = 0, stall_prev = 0;
  out_t stall_val;
  out_t exp_q[$], cap_q[$];
  logic [7:0] img [LN][LW];

  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(posedge clk); #1;
    ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // output monitor: captures handshakes and checks hold-while-stalled
  initial forever begin
    @(negedge clk);
    if (!rstn_i) stall_prev = 0;
    else begin
      if (stall_prev) begin
        checks++;
        if (valid_o !== 1'b1 || {data_o, eol_o, eof_o} !== stall_val) begin
          failures++;
          $display("FAIL stall_hold got v=%b d=%h eol=%b eof=%b need v=1 d=%h eol=%b eof=%b",
                   valid_o, data_o, eol_o, eof_o, stall_val.d, stall_val.eol, stall_val.eof);
        end
      end
      stall_prev = valid_o && !ready_i;
      stall_val  = {data_o, eol_o, eof_o};
      if (valid_o === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid_o && ready_i) cap_q.push_back({data_o, eol_o, eof_o});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // reference: convolve the stored frame around every interior centre pixel
  function automatic void add_expected(input int mode, input int thresh);
    for (int r = 1; r < LN - 1; r++)
      for (int c = 1; c < LW - 1; c++) begin
        int gx, gy, v;
        gx = (int'(img[r-1][c+1]) + 2*int'(img[r][c+1]) + int'(img[r+1][c+1]))
           - (int'(img[r-1][c-1]) + 2*int'(img[r][c-1]) + int'(img[r+1][c-1]));
        gy = (int'(img[r+1][c-1]) + 2*int'(img[r+1][c]) + int'(img[r+1][c+1]))
           - (int'(img[r-1][c-1]) + 2*int'(img[r-1][c]) + int'(img[r-1][c+1]));
        case (mode)
          0: v = sat(iabs(gx) + iabs(gy));
          1: v = (sat(iabs(gx) + iabs(gy)) >= thresh) ? 255 : 0;
          2: v = sat(iabs(gx));
          default: v = sat(iabs(gy));
        endcase
        exp_q.push_back({8'(v), c == LW - 2, (c == LW - 2) && (r == LN - 2)});
      end
  endfunction

  task automatic apply_reset();
    valid_i = 0;
    rstn_i  = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rstn_i = 1;
    @(posedge clk); #1;
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic send_pixel(input logic [7:0] d, input logic [1:0] m, input logic [7:0] t,
                            input bit track, output bit ok);
    bit hs;
    int c;
    valid_i = 1; data_i = d; mode_i = m; thresh_i = t; ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); hs = ready_o; c = cyc;
      @(posedge clk); #1;
      if (hs) begin ok = 1; if (track) acc_cyc = c; break; end
    end
  endtask

  // mode m1 applies from input row sw_row on; junk scrambles mode/thresh off pixel (0,0)
  task automatic drive_frame(input int n_pix, input logic [1:0] m0, input logic [1:0] m1,
                             input int sw_row, input logic [7:0] t, input bit junk,
                             output int timeouts);
    bit ok;
    timeouts = 0;
    for (int i = 0; i < n_pix; i++) begin
      int r, c;
      logic [1:0] m;
      logic [7:0] tt;
      r = i / LW; c = i % LW;
      m = (r >= sw_row) ? m1 : m0;
      tt = t;
      if (junk && i != 0) begin m = 2'($urandom); tt = 8'($urandom); end
      send_pixel(img[r][c], m, tt, (r == 2) && (c == 2), ok);
      if (!ok) timeouts++;
    end
    valid_i = 0;
  endtask

  task automatic wait_outputs(input int n);
    for (int i = 0; i < 3000 && cap_q.size() < n; i++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic fill_flat();
    for (int r = 0; r < LN; r++) for (int c = 0; c < LW; c++) img[r][c] = 8'h80;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < LN; r++) for (int c = 0; c < LW; c++) img[r][c] = 8'(c * 8);
  endtask

  task automatic fill_vstep();
    for (int r = 0; r < LN; r++) for (int c = 0; c < LW; c++) img[r][c] = (c < 4) ? 8'h00 : 8'hFF;
  endtask

  task automatic fill_random();
    for (int r = 0; r < LN; r++) for (int c = 0; c < LW; c++) img[r][c] = 8'($urandom);
  endtask

  task automatic test_reset();
    rstn_i = 0; ready_i = 1;
    #3;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got %b need 0", valid_o); end
    checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data got %h need 00", data_o); end
    checks++; if (eol_o !== 1'b0) begin failures++; $display("FAIL reset_eol got %b need 0", eol_o); end
    checks++; if (eof_o !== 1'b0) begin failures++; $display("FAIL reset_eof got %b need 0", eof_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got %b need 1", ready_o); end
`ifdef SOBEL_STREAM_STATS_EN
    checks++; if (frame_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_fcnt got %0d need 0", frame_cnt_o); end
`endif
    apply_reset();
  endtask

  task automatic test_flat();
    int to;
    apply_reset();
    first_valid_cyc = -1;
    fill_flat();
    add_expected(0, 0);
    drive_frame(LN * LW, 2'd0, 2'd0, LN, 8'd0, 0, to);
    wait_outputs(exp_q.size());
    checks++; if (to !== 0) begin failures++; $display("FAIL flat_timeout got %0d need 0", to); end
    checks++; if (first_valid_cyc - acc_cyc !== 2) begin
      failures++; $display("FAIL flat_latency got %0d need 2", first_valid_cyc - acc_cyc); end
    checks++; if (cap_q.size() !== 24) begin failures++; $display("FAIL flat_count got %0d need 24", cap_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin failures++;
        $display("FAIL flat_out[%0d] got d=%h eol=%b eof=%b need d=%h eol=%b eof=%b", i,
                 cap_q[i].d, cap_q[i].eol, cap_q[i].eof, exp_q[i].d, exp_q[i].eol, exp_q[i].eof); end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_modes();
    int to, tt = 0;
    fill_vstep(); add_expected(2, 0); drive_frame(LN * LW, 2'd2, 2'd2, LN, 8'd0, 0, to); tt += to;
    add_expected(3, 0); drive_frame(LN * LW, 2'd3, 2'd3, LN, 8'd0, 0, to); tt += to;
    fill_ramp();
    add_expected(0, 0);    drive_frame(LN * LW, 2'd0, 2'd0, LN, 8'h00, 0, to); tt += to;
    add_expected(1, 'h40); drive_frame(LN * LW, 2'd1, 2'd1, LN, 8'h40, 0, to); tt += to;
    add_expected(1, 'h41); drive_frame(LN * LW, 2'd1, 2'd1, LN, 8'h41, 0, to); tt += to;
    wait_outputs(exp_q.size());
    checks++; if (tt !== 0) begin failures++; $display("FAIL modes_timeout got %0d need 0", tt); end
    checks++; if (cap_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL modes_count got %0d need %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin failures++;
        $display("FAIL modes_out[%0d] got d=%h eol=%b eof=%b need d=%h eol=%b eof=%b", i,
                 cap_q[i].d, cap_q[i].eol, cap_q[i].eof, exp_q[i].d, exp_q[i].eol, exp_q[i].eof); end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_back_to_back();
    int to, tt = 0;
    for (int f = 0; f < 3; f++) begin
      logic [1:0] m;
      logic [7:0] t;
      m = 2'($urandom); t = 8'($urandom);
      fill_random();
      add_expected(int'(m), int'(t));
      drive_frame(LN * LW, m, m, LN, t, 1, to); tt += to;
    end
    wait_outputs(exp_q.size());
    checks++; if (tt !== 0) begin failures++; $display("FAIL b2b_timeout got %0d need 0", tt); end
    checks++; if (cap_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL b2b_count got %0d need %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin failures++;
        $display("FAIL b2b_out[%0d] got d=%h eol=%b eof=%b need d=%h eol=%b eof=%b", i,
                 cap_q[i].d, cap_q[i].eol, cap_q[i].eof, exp_q[i].d, exp_q[i].eol, exp_q[i].eof); end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_backpressure();
    int to, tt = 0;
    logic [1:0] m;
    logic [7:0] t;
    bp_en = 1;
    fill_ramp(); add_expected(0, 0); drive_frame(LN * LW, 2'd0, 2'd0, LN, 8'd0, 0, to); tt += to;
    m = 2'($urandom); t = 8'($urandom);
    fill_random(); add_expected(int'(m), int'(t)); drive_frame(LN * LW, m, m, LN, t, 1, to); tt += to;
    wait_outputs(exp_q.size());
    bp_en = 0;
    repeat (2) @(posedge clk); #1;
    checks++; if (tt !== 0) begin failures++; $display("FAIL bp_timeout got %0d need 0", tt); end
    checks++; if (cap_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL bp_count got %0d need %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin failures++;
        $display("FAIL bp_out[%0d] got d=%h eol=%b eof=%b need d=%h eol=%b eof=%b", i,
                 cap_q[i].d, cap_q[i].eol, cap_q[i].eof, exp_q[i].d, exp_q[i].eol, exp_q[i].eof); end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_mode_switch();
    int to, tt = 0;
    apply_reset();
    fill_random(); add_expected(0, 0);
    drive_frame(LN * LW, 2'd0, 2'd2, 3, 8'd0, 0, to); tt += to;
    wait_outputs(exp_q.size());
`ifdef SOBEL_STREAM_STATS_EN
    checks++; if (frame_cnt_o !== 16'd1) begin failures++; $display("FAIL fcnt_1 got %0d need 1", frame_cnt_o); end
`endif
    fill_random(); add_expected(2, 0);
    drive_frame(LN * LW, 2'd2, 2'd2, LN, 8'd0, 0, to); tt += to;
    wait_outputs(exp_q.size());
`ifdef SOBEL_STREAM_STATS_EN
    checks++; if (frame_cnt_o !== 16'd2) begin failures++; $display("FAIL fcnt_2 got %0d need 2", frame_cnt_o); end
`endif
    checks++; if (tt !== 0) begin failures++; $display("FAIL msw_timeout got %0d need 0", tt); end
    checks++; if (cap_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL msw_count got %0d need %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin failures++;
        $display("FAIL msw_out[%0d] got d=%h eol=%b eof=%b need d=%h eol=%b eof=%b", i,
                 cap_q[i].d, cap_q[i].eol, cap_q[i].eof, exp_q[i].d, exp_q[i].eol, exp_q[i].eof); end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_mid_reset();
    int to;
    fill_random();
    drive_frame(2 * LW + 6, 2'd0, 2'd0, LN, 8'd0, 0, to);
    #2;
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got %b need 1", valid_o); end
    rstn_i = 0;
    #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got %b need 0", valid_o); end
    checks++; if ({eol_o, eof_o} !== 2'b00) begin failures++; $display("FAIL midrst_flags got %b need 00", {eol_o, eof_o}); end
    @(negedge clk); rstn_i = 1;
    @(posedge clk); #1;
    cap_q.delete(); exp_q.delete();
    fill_flat(); add_expected(0, 0);
    drive_frame(LN * LW, 2'd0, 2'd0, LN, 8'd0, 0, to);
    wait_outputs(exp_q.size());
    checks++; if (to !== 0) begin failures++; $display("FAIL midrst_timeout got %0d need 0", to); end
    checks++; if (cap_q.size() !== 24) begin failures++; $display("FAIL midrst_count got %0d need 24", cap_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin failures++;
        $display("FAIL midrst_out[%0d] got d=%h eol=%b eof=%b need d=%h eol=%b eof=%b", i,
                 cap_q[i].d, cap_q[i].eol, cap_q[i].eof, exp_q[i].d, exp_q[i].eol, exp_q[i].eof); end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  initial begin
    test_reset();
    test_flat();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_mode_switch();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
